// File: rtl/alu_pkg.sv
// Shared opcode and compare-result definitions
// for the 16-bit registered ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_MUL    = 4'b0010;
  localparam logic [3:0] OP_DIV    = 4'b0011;
  localparam logic [3:0] OP_AND    = 4'b0100;
  localparam logic [3:0] OP_OR     = 4'b0101;
  localparam logic [3:0] OP_NAND   = 4'b0110;
  localparam logic [3:0] OP_NOR    = 4'b0111;
  localparam logic [3:0] OP_XOR    = 4'b1000;
  localparam logic [3:0] OP_XNOR   = 4'b1001;
  localparam logic [3:0] OP_CMP_EQ = 4'b1010;
  localparam logic [3:0] OP_CMP_GT = 4'b1011;
  localparam logic [3:0] OP_CMP_LT = 4'b1100;
  localparam logic [3:0] OP_SHR    = 4'b1101;
  localparam logic [3:0] OP_SHL    = 4'b1110;
  localparam logic [3:0] OP_NOP    = 4'b1111;

  localparam logic [1:0] CMP_EQ_VAL = 2'd1;
  localparam logic [1:0] CMP_GT_VAL = 2'd2;
  localparam logic [1:0] CMP_LT_VAL = 2'd3;

endpackage

// File: rtl/alu_16bit_comb.sv
// Combinational ALU datapath: result select
// and opcode-class flag decode, no state.
module alu_16bit_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         alu_fun,
  output logic [2*WIDTH-1:0] result,
  output logic               arith_flag,
  output logic               logic_flag,
  output logic               cmp_flag,
  output logic               shift_flag
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    ax;
  logic [W2-1:0]    bx;
  logic [WIDTH-1:0] zh;
  logic [W2-3:0]    zc;

  assign ax = {{WIDTH{1'b0}}, a};
  assign bx = {{WIDTH{1'b0}}, b};
  assign zh = '0;
  assign zc = '0;

  // Result mux over zero-extended operands
  always_comb begin
    result = '0;
    case (alu_fun)
      OP_ADD:    result = ax + bx;
      OP_SUB:    result = ax - bx;
      OP_MUL:    result = ax * bx;
      OP_DIV:    result = (b == '0) ? '0
                                    : ax / bx;
      OP_AND:    result = {zh, a & b};
      OP_OR:     result = {zh, a | b};
      OP_NAND:   result = {zh, ~(a & b)};
      OP_NOR:    result = {zh, ~(a | b)};
      OP_XOR:    result = {zh, a ^ b};
      OP_XNOR:   result = {zh, ~(a ^ b)};
      OP_CMP_EQ: result = (a == b)
                          ? {zc, CMP_EQ_VAL} : '0;
      OP_CMP_GT: result = (a > b)
                          ? {zc, CMP_GT_VAL} : '0;
      OP_CMP_LT: result = (a < b)
                          ? {zc, CMP_LT_VAL} : '0;
      OP_SHR:    result = ax >> 1;
      OP_SHL:    result = ax << 1;
      default:   result = '0;
    endcase
  end

  // Class flags depend on opcode only
  always_comb begin
    arith_flag = 1'b0;
    logic_flag = 1'b0;
    cmp_flag   = 1'b0;
    shift_flag = 1'b0;
    unique case (1'b1)
      (alu_fun <= OP_DIV):
        arith_flag = 1'b1;
      (alu_fun >= OP_AND &&
       alu_fun <= OP_XNOR):
        logic_flag = 1'b1;
      (alu_fun >= OP_CMP_EQ &&
       alu_fun <= OP_CMP_LT):
        cmp_flag = 1'b1;
      (alu_fun == OP_SHR ||
       alu_fun == OP_SHL):
        shift_flag = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_16bit_core.sv
// Registered 16-bit ALU: combinational core
// followed by a resettable output register.
module alu_16bit_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         ALU_FUN,
  output logic [2*WIDTH-1:0] ALU_OUT,
  output logic               arith_flag,
  output logic               logic_flag,
  output logic               cmp_flag,
  output logic               shift_flag
);

  logic [2*WIDTH-1:0] res_c;
  logic               ar_c;
  logic               lg_c;
  logic               cp_c;
  logic               sh_c;

  alu_16bit_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .a          (A),
    .b          (B),
    .alu_fun    (ALU_FUN),
    .result     (res_c),
    .arith_flag (ar_c),
    .logic_flag (lg_c),
    .cmp_flag   (cp_c),
    .shift_flag (sh_c)
  );

  // Output register, reset clears all
  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_OUT    <= '0;
      arith_flag <= 1'b0;
      logic_flag <= 1'b0;
      cmp_flag   <= 1'b0;
      shift_flag <= 1'b0;
    end else begin
      ALU_OUT    <= res_c;
      arith_flag <= ar_c;
      logic_flag <= lg_c;
      cmp_flag   <= cp_c;
      shift_flag <= sh_c;
    end
  end

endmodule

// File: tb/tb_alu_16bit_core.sv
// Directed and random checks for the
// registered 16-bit ALU.
module tb_alu_16bit_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  fun;
  logic [31:0] alu_out;
  logic        arith_flag;
  logic        logic_flag;
  logic        cmp_flag;
  logic        shift_flag;

  int n_run  = 0;
  int n_fail = 0;

  alu_16bit_core dut (
    .CLK        (clk),
    .RST        (rst),
    .A          (a),
    .B          (b),
    .ALU_FUN    (fun),
    .ALU_OUT    (alu_out),
    .arith_flag (arith_flag),
    .logic_flag (logic_flag),
    .cmp_flag   (cmp_flag),
    .shift_flag (shift_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] obs();
    return {arith_flag, logic_flag,
            cmp_flag, shift_flag, alu_out};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [35:0] got,
    input logic [35:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  // flags {arith,logic,cmp,shift} + result
  function automatic logic [35:0] model(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [3:0]  op
  );
    logic [31:0] r;
    logic [3:0]  f;
    r = 32'h0;
    f = 4'b0000;
    case (op)
      4'd0:  begin r = x + y;      f = 4'b1000; end
      4'd1:  begin r = {16'h0, x} - {16'h0, y};
                   f = 4'b1000; end
      4'd2:  begin r = x * y;      f = 4'b1000; end
      4'd3:  begin r = (y == 0) ? 32'h0 : x / y;
                   f = 4'b1000; end
      4'd4:  begin r = {16'h0, x & y};    f = 4'b0100; end
      4'd5:  begin r = {16'h0, x | y};    f = 4'b0100; end
      4'd6:  begin r = {16'h0, ~(x & y)}; f = 4'b0100; end
      4'd7:  begin r = {16'h0, ~(x | y)}; f = 4'b0100; end
      4'd8:  begin r = {16'h0, x ^ y};    f = 4'b0100; end
      4'd9:  begin r = {16'h0, ~(x ^ y)}; f = 4'b0100; end
      4'd10: begin r = (x == y) ? 1 : 0; f = 4'b0010; end
      4'd11: begin r = (x > y) ? 2 : 0;  f = 4'b0010; end
      4'd12: begin r = (x < y) ? 3 : 0;  f = 4'b0010; end
      4'd13: begin r = {17'h0, x[15:1]}; f = 4'b0001; end
      4'd14: begin r = {15'h0, x, 1'b0}; f = 4'b0001; end
      default: begin r = 32'h0; f = 4'b0000; end
    endcase
    return {f, r};
  endfunction

  task automatic step(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [3:0]  op
  );
    a   = x;
    b   = y;
    fun = op;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(
    input string       tag,
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [3:0]  op,
    input logic [3:0]  f,
    input logic [31:0] r
  );
    step(x, y, op);
    chk(tag, obs(), {f, r});
  endtask

  localparam logic [3:0] FA = 4'b1000;
  localparam logic [3:0] FL = 4'b0100;
  localparam logic [3:0] FC = 4'b0010;
  localparam logic [3:0] FS = 4'b0001;

  initial begin
    logic [35:0] exp;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [3:0]  rf;

    rst = 1'b1;
    a   = 16'd5;
    b   = 16'd3;
    fun = 4'b0000;
    @(posedge clk); #1;
    chk("rst_c1", obs(), 36'h0);
    @(posedge clk); #1;
    chk("rst_c2", obs(), 36'h0);
    rst = 1'b0;
    vec("rst_rel", 16'd5, 16'd3, 4'd0, FA, 32'd8);

    vec("add_cy", 16'hFFFF, 16'h0001, 4'd0,
        FA, 32'h0001_0000);
    vec("sub_wr", 16'h0000, 16'h0001, 4'd1,
        FA, 32'hFFFF_FFFF);
    vec("mul_mx", 16'hFFFF, 16'hFFFF, 4'd2,
        FA, 32'hFFFE_0001);
    vec("div",    16'd7, 16'd2, 4'd3, FA, 32'd3);
    vec("div0",   16'd7, 16'd0, 4'd3, FA, 32'd0);

    vec("and",  16'hF0F0, 16'hFF00, 4'd4, FL, 32'hF000);
    vec("or",   16'hF0F0, 16'hFF00, 4'd5, FL, 32'hFFF0);
    vec("nand", 16'hF0F0, 16'hFF00, 4'd6, FL, 32'h0FFF);
    vec("nor",  16'hF0F0, 16'hFF00, 4'd7, FL, 32'h000F);
    vec("xor",  16'hF0F0, 16'hFF00, 4'd8, FL, 32'h0FF0);
    vec("xnor", 16'hF0F0, 16'hFF00, 4'd9, FL, 32'hF00F);

    vec("eq_t",  16'h1234, 16'h1234, 4'd10, FC, 32'd1);
    vec("gt_f",  16'h1234, 16'h1234, 4'd11, FC, 32'd0);
    vec("lt_f",  16'h1234, 16'h1234, 4'd12, FC, 32'd0);
    vec("gt_t",  16'd2, 16'd1, 4'd11, FC, 32'd2);
    vec("lt_t",  16'd1, 16'd2, 4'd12, FC, 32'd3);
    vec("eq_f",  16'd1, 16'd2, 4'd10, FC, 32'd0);

    vec("shr", 16'h8001, 16'h0, 4'd13, FS, 32'h4000);
    vec("shl", 16'h8001, 16'h0, 4'd14, FS,
        32'h0001_0002);
    vec("nop", 16'hFFFF, 16'hFFFF, 4'd15,
        4'b0000, 32'h0);

    // back-to-back: one result per edge
    vec("b2b_add", 16'd100, 16'd23, 4'd0, FA, 32'd123);
    vec("b2b_sub", 16'd100, 16'd23, 4'd1, FA, 32'd77);
    vec("b2b_mul", 16'd100, 16'd23, 4'd2, FA, 32'd2300);
    vec("b2b_div", 16'd100, 16'd23, 4'd3, FA, 32'd4);

    for (int i = 0; i < 10000; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rf  = 4'($urandom);
      if (i % 8 == 0) rb = ra;
      if (i % 16 == 1) rb = 16'h0;
      rst = ($urandom_range(0, 99) == 0);
      exp = rst ? 36'h0 : model(ra, rb, rf);
      step(ra, rb, rf);
      chk("rand", obs(), exp);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
